prbs5_checker: RTL and testbench

//  Receive-side partner of the 5-bit LFSR pattern source in DDS_Modulation.
//  - Takes the serial PRBS bit stream (the LFSR LSB, after the modulation/demod path) with a valid strobe.
//  - Self-synchronises to the sequence and declares lock.
//  - Counts bit errors and detects loss of lock.
//  - Used on hardware and in simulation to prove the modulation chain end to end.

---
 rtl/prbs5_checker_pkg.sv | 19 +
 rtl/prbs_hist_reg.sv | 31 +++
 rtl/prbs5_checker.sv | 177 +++++++++++++++++
 tb/tb_prbs5_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs5_checker_pkg.sv
// Shared PRBS5 definitions: checker states, default taps and the next-bit recurrence.
// Used by the checker RTL and by any pattern generator model.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int PRBS5_LEN = 5;
  localparam int PRBS5_TAP = 3;

  // hist[0] is the newest bit; returns b[n] = b[n-TAP] ^ b[n-LEN]
  function automatic logic prbs_next(input logic [PRBS5_LEN-1:0] hist);
    return hist[PRBS5_TAP-1] ^ hist[PRBS5_LEN-1];
  endfunction

endpackage

// File: rtl/prbs_hist_reg.sv
// PRBS history shift register with predictor and all-zero flag.
// Shifts in either the received bit (self-sync) or its own prediction (free-run).
module prbs_hist_reg #(
  parameter int W   = 5,
  parameter int TAP = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic shift_i,
  input  logic free_run_i,
  input  logic bit_i,
  output logic pred_o,
  output logic zero_o
);

  logic [W-1:0] hist_q, hist_d;

  assign pred_o = hist_q[TAP-1] ^ hist_q[W-1];
  assign zero_o = (hist_q == '0);

  always_comb begin
    hist_d = hist_q;
    if (shift_i) hist_d = {hist_q[W-2:0], (free_run_i ? pred_o : bit_i)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= '0;
    else         hist_q <= hist_d;
  end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS checker: HUNT -> SYNC -> LOCKED, error counting, loss-of-lock.
// Optional PRBS_CHK_WINDOW_EN adds per-window error reporting (win_err_cnt, win_done).
module prbs5_checker
  import prbs_pkg::*;
#(
  parameter int LFSR_W   = PRBS5_LEN,
  parameter int TAP_A    = PRBS5_TAP,
  parameter int LOCK_CNT = 31,
  parameter int LOSS_ERR = 4,
  parameter int LOSS_WIN = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse,
  output logic             lock_lost
`ifdef PRBS_CHK_WINDOW_EN
  ,
  output logic [7:0]       win_err_cnt,
  output logic             win_done
`endif
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(LOSS_WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_ERR + 1);

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WIN_W-1:0]    wcnt_q, wcnt_d;
  logic [WERR_W-1:0]   werr_q, werr_d, werr_nxt;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                locked_q, err_pulse_q, err_pulse_d, lock_lost_q, lock_lost_d;
  logic                shift, free_run, pred, hist_zero, bit_err;
`ifdef PRBS_CHK_WINDOW_EN
  logic [7:0]          win_err_q, win_err_d;
  logic                win_done_q, win_done_d;
`endif

  prbs_hist_reg #(.W(LFSR_W), .TAP(TAP_A)) u_hist (
    .clk_i      (clk),
    .rst_ni     (reset),
    .shift_i    (shift),
    .free_run_i (free_run),
    .bit_i      (bit_in),
    .pred_o     (pred),
    .zero_o     (hist_zero)
  );

  assign bit_err  = (bit_in != pred);
  assign werr_nxt = werr_q + WERR_W'(bit_err);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    shift       = 1'b0;
    free_run    = 1'b0;
`ifdef PRBS_CHK_WINDOW_EN
    win_err_d   = win_err_q;
    win_done_d  = 1'b0;
`endif
    if (bit_valid) begin
      shift = 1'b1;
      unique case (state_q)
        HUNT: begin
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            state_d = SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        SYNC: begin
          // an all-zero history predicts zeros forever, so it never counts as a match
          if (bit_err || hist_zero) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            match_d = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          free_run = 1'b1;
          if (bit_err) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          if (werr_nxt == WERR_W'(LOSS_ERR)) begin
            state_d     = HUNT;
            fill_d      = '0;
            wcnt_d      = '0;
            werr_d      = '0;
            lock_lost_d = 1'b1;
`ifdef PRBS_CHK_WINDOW_EN
            win_err_d   = '0;
`endif
          end else if (wcnt_q == WIN_W'(LOSS_WIN - 1)) begin
            wcnt_d = '0;
            werr_d = '0;
`ifdef PRBS_CHK_WINDOW_EN
            win_err_d  = (int'(werr_nxt) > 255) ? 8'hFF : 8'(werr_nxt);
            win_done_d = 1'b1;
`endif
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            werr_d = werr_nxt;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clr_err) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      wcnt_q      <= '0;
      werr_q      <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wcnt_q      <= wcnt_d;
      werr_q      <= werr_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PRBS_CHK_WINDOW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_err_q  <= '0;
      win_done_q <= 1'b0;
    end else begin
      win_err_q  <= win_err_d;
      win_done_q <= win_done_d;
    end
  end

  assign win_err_cnt = win_err_q;
  assign win_done    = win_done_q;
`endif

  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: lock, single error, loss/relock, dead line,
// gapped valid with async reset, and counter saturation on a CNT_W=4 instance.
module tb_prbs5_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4, lock_lost4;
  logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_WINDOW_EN
  logic [7:0]  win_err_cnt, win_err_cnt4;
  logic        win_done, win_done4;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [4:0]  g = 5'b00001;
  int          since_lock = 0;
  int          pulses = 0;
  int          losts = 0;
  int          ever_locked = 0;

  always #5 clk = ~clk;

  prbs5_checker dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .locked(locked), .err_cnt(err_cnt), .err_pulse(err_pulse), .lock_lost(lock_lost)
`ifdef PRBS_CHK_WINDOW_EN
    , .win_err_cnt(win_err_cnt), .win_done(win_done)
`endif
  );

  prbs5_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .locked(locked4), .err_cnt(err_cnt4), .err_pulse(err_pulse4), .lock_lost(lock_lost4)
`ifdef PRBS_CHK_WINDOW_EN
    , .win_err_cnt(win_err_cnt4), .win_done(win_done4)
`endif
  );

  // one valid bit, then `gap` idle cycles; outputs are sampled 1ns after each edge
  task automatic push(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    since_lock++;
    if (err_pulse) pulses++;
    if (lock_lost) losts++;
    if (locked) ever_locked++;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic flip, input int gap);
    logic b;
    b = prbs_next(g);
    g = {g[3:0], b};
    push(b ^ flip, gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic align_window();
    while (since_lock % 31 != 0) send(1'b0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_chk++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_chk++; if (err_pulse !== 1'b0 || lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got err_pulse=%b lock_lost=%b want 0 0", err_pulse, lock_lost);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_lock();
    g = 5'b00001;
    repeat (35) send(1'b0, 0);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got locked=%b after 35 bits want 0", locked); end
    send(1'b0, 0);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_36: got locked=%b after 36 bits want 1", locked); end
    since_lock = 0;
    pulses = 0;
    ever_locked = 0;
    repeat (200) send(1'b0, 0);
    n_chk++; if (err_cnt !== 16'd0 || pulses != 0) begin
      n_fail++; $display("FAIL clean_200: got err_cnt=%0d pulses=%0d want 0 0", err_cnt, pulses);
    end
    n_chk++; if (ever_locked != 200) begin n_fail++; $display("FAIL lock_hold: got locked on %0d of 200 bits want 200", ever_locked); end
  endtask

  task automatic test_single_error();
    pulses = 0;
    send(1'b1, 0);
    n_chk++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse_latency: got %b want 1", err_pulse); end
    repeat (20) send(1'b0, 0);
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL single_err_pulses: got %0d want 1", pulses); end
    n_chk++; if (err_cnt !== 16'd1 || locked !== 1'b1) begin
      n_fail++; $display("FAIL single_err_cnt: got err_cnt=%0d locked=%b want 1 1", err_cnt, locked);
    end
  endtask

  task automatic test_loss_relock();
    pulse_clr();
    n_chk++; if (err_cnt !== 16'd0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL clr_err: got err_cnt=%0d locked=%b want 0 1", err_cnt, locked);
    end
    align_window();
    losts = 0;
    repeat (3) send(1'b1, 0);
    n_chk++; if (locked !== 1'b1 || lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL three_errs: got locked=%b lock_lost=%b want 1 0", locked, lock_lost);
    end
    send(1'b1, 0);
    n_chk++; if (lock_lost !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL loss: got lock_lost=%b locked=%b want 1 0", lock_lost, locked);
    end
    repeat (5) send(1'b0, 0);
    n_chk++; if (losts != 1 || err_cnt !== 16'd4) begin
      n_fail++; $display("FAIL loss_once: got lock_lost pulses=%0d err_cnt=%0d want 1 4", losts, err_cnt);
    end
    repeat (30) send(1'b0, 0);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got locked=%b want 0", locked); end
    send(1'b0, 0);
    since_lock = 0;
    n_chk++; if (locked !== 1'b1 || err_cnt !== 16'd4) begin
      n_fail++; $display("FAIL relock: got locked=%b err_cnt=%0d want 1 4", locked, err_cnt);
    end
  endtask

  task automatic test_dead_line();
    pulse_reset();
    pulses = 0;
    ever_locked = 0;
    repeat (100) push(1'b0, 0);
    n_chk++; if (ever_locked != 0) begin n_fail++; $display("FAIL dead_line_lock: got locked on %0d bits want 0", ever_locked); end
    n_chk++; if (err_cnt !== 16'd0 || pulses != 0) begin
      n_fail++; $display("FAIL dead_line_err: got err_cnt=%0d pulses=%0d want 0 0", err_cnt, pulses);
    end
  endtask

  task automatic test_gappy_reset();
    pulse_reset();
    g = 5'b00001;
    repeat (35) send(1'b0, 2);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_lock_early: got locked=%b want 0", locked); end
    send(1'b0, 2);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_lock: got locked=%b want 1", locked); end
    send(1'b1, 2);
    repeat (10) send(1'b0, 2);
    n_chk++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL gap_err: got err_cnt=%0d want 1", err_cnt); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (locked !== 1'b0 || err_cnt !== 16'd0 || err_pulse !== 1'b0 || lock_lost !== 1'b0 || locked4 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got locked=%b err_cnt=%0d err_pulse=%b lock_lost=%b locked4=%b want all 0",
                         locked, err_cnt, err_pulse, lock_lost, locked4);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    repeat (35) send(1'b0, 2);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_relock_early: got locked=%b want 0", locked); end
    send(1'b0, 2);
    since_lock = 0;
    n_chk++; if (locked !== 1'b1 || locked4 !== 1'b1) begin
      n_fail++; $display("FAIL gap_relock: got locked=%b locked4=%b want 1 1", locked, locked4);
    end
  endtask

  task automatic test_saturate();
    for (int w = 0; w < 6; w++) begin
      align_window();
      repeat (3) send(1'b1, 0);
      repeat (28) send(1'b0, 0);
`ifdef PRBS_CHK_WINDOW_EN
      if (w == 0) begin
        n_chk++; if (win_err_cnt !== 8'd3 || win_done !== 1'b1) begin
          n_fail++; $display("FAIL win_err: got win_err_cnt=%0d win_done=%b want 3 1", win_err_cnt, win_done);
        end
      end
`endif
      if (w == 3) begin
        n_chk++; if (err_cnt4 !== 4'd12) begin n_fail++; $display("FAIL cnt4_12: got %0d want 12", err_cnt4); end
      end
    end
    n_chk++; if (err_cnt4 !== 4'd15 || locked4 !== 1'b1) begin
      n_fail++; $display("FAIL cnt4_sat: got err_cnt4=%0d locked4=%b want 15 1", err_cnt4, locked4);
    end
    n_chk++; if (err_cnt !== 16'd18) begin n_fail++; $display("FAIL cnt16_18: got %0d want 18", err_cnt); end
    clr_err = 1'b1;
    send(1'b1, 0);
    clr_err = 1'b0;
    n_chk++; if (err_cnt4 !== 4'd0 || err_cnt !== 16'd0 || err_pulse !== 1'b1) begin
      n_fail++; $display("FAIL clr_wins: got err_cnt4=%0d err_cnt=%0d err_pulse=%b want 0 0 1", err_cnt4, err_cnt, err_pulse);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_dead_line();
    test_gappy_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
